// File: rtl/sym_fir_bits_if.sv
// Handshake/bus bundle for sym_fir_bits: bitstream, filter request,
// coefficient port and the registered sample/status outputs.
interface sym_fir_bits_if #(
    parameter int NTAPS = 512,
    parameter int CW    = 16,
    parameter int OW    = 16
);
    logic                          BitIn;
    logic                          BitValid;
    logic                          FILTER;
    logic                          CoefWe;
    logic [$clog2(NTAPS/2)-1:0]    CoefAddr;
    logic signed [CW-1:0]          CoefData;
    logic signed [OW-1:0]          Dout;
    logic                          Push;
    logic                          Sat;
    logic                          Busy;
    logic                          Overrun;
    logic                          CoefErr;

    modport master (
        output BitIn, BitValid, FILTER, CoefWe, CoefAddr, CoefData,
        input  Dout, Push, Sat, Busy, Overrun, CoefErr
    );
    modport slave (
        input  BitIn, BitValid, FILTER, CoefWe, CoefAddr, CoefData,
        output Dout, Push, Sat, Busy, Overrun, CoefErr
    );
endinterface

// File: rtl/sym_fir_bits.sv
// Symmetric FIR decimator over a 1-bit stream: snapshots the tap window on
// FILTER, folds LANES symmetric pairs per cycle, emits one rounded sample.
module sym_fir_lane #(
    parameter int CW = 16
) (
    input  logic                 bit_lo,
    input  logic                 bit_hi,
    input  logic signed [CW-1:0] coef,
    output logic signed [CW:0]   term
);
    // Pair sum is 0/1/2, so the product is zero, h, or h shifted left.
    always_comb begin
        unique case ({bit_hi, bit_lo})
            2'b11:        term = {coef, 1'b0};
            2'b01, 2'b10: term = {coef[CW-1], coef};
            default:      term = '0;
        endcase
    end
endmodule

module sym_fir_bits #(
    parameter int NTAPS = 512,
    parameter int LANES = 2,
    parameter int CW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    sym_fir_bits_if.slave  bus
);
    localparam int NP = NTAPS / 2;
    localparam int PW = $clog2(NP);
    localparam int TW = $clog2(NTAPS);
    localparam int AW = CW + TW + 1;
    localparam int RW = (AW > OW) ? AW + 1 : OW + 1;
    localparam logic signed [RW-1:0] RND  = (SHIFT == 0) ? '0 : RW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1);
    localparam logic signed [RW-1:0] MAXV = RW'((longint'(1) <<< (OW - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                   state, state_nxt;
    logic [NTAPS-1:0]         win, win_nxt, snap;
    logic [PW-1:0]            cnt;
    logic signed [AW-1:0]     acc, lane_sum;
    logic signed [CW-1:0]     h [NP];
    logic                     start, last, busy;
    logic [LANES-1:0]         bits_lo, bits_hi;
    logic [LANES-1:0][CW-1:0] coefs;
    logic [LANES-1:0][CW:0]   terms;
    logic signed [RW-1:0]     rsum, rsh;
    logic                     sat_hi, sat_lo;

    assign win_nxt  = bus.BitValid ? {win[NTAPS-2:0], bus.BitIn} : win;
    assign last     = (cnt == PW'(NP - LANES));
    assign busy     = (state == CALC);
    assign bus.Busy = busy;

    // Mirror tap NTAPS-1-k is the bitwise complement of {0,k} since NTAPS is 2^n.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PW-1:0] k;
        assign k          = cnt + PW'(l);
        assign bits_lo[l] = snap[{1'b0, k}];
        assign bits_hi[l] = snap[{1'b1, ~k}];
        assign coefs[l]   = h[k];
    end

    sym_fir_lane #(.CW(CW)) u_lane [LANES-1:0] (
        .bit_lo (bits_lo),
        .bit_hi (bits_hi),
        .coef   (coefs),
        .term   (terms)
    );

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) lane_sum += AW'($signed(terms[l]));
    end

    assign rsum   = RW'(acc) + RND;
    assign rsh    = rsum >>> SHIFT;
    assign sat_hi = rsh > MAXV;
    assign sat_lo = rsh < MINV;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            IDLE: if (bus.FILTER) begin
                state_nxt = CALC;
                start     = 1'b1;
            end
            CALC:    if (last) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            win         <= '0;
            snap        <= '0;
            acc         <= '0;
            cnt         <= '0;
            bus.Dout    <= '0;
            bus.Sat     <= 1'b0;
            bus.Push    <= 1'b0;
            bus.Overrun <= 1'b0;
            bus.CoefErr <= 1'b0;
        end else begin
            win         <= win_nxt;
            bus.Push    <= (state == OUT);
            bus.Overrun <= bus.FILTER && busy;
            bus.CoefErr <= bus.CoefWe && busy;
            if (start) begin
                snap <= win_nxt;
                acc  <= '0;
                cnt  <= '0;
            end else if (busy) begin
                acc <= acc + lane_sum;
                cnt <= cnt + PW'(LANES);
            end
            if (state == OUT) begin
                bus.Dout <= sat_hi ? OW'(MAXV) : sat_lo ? OW'(MINV) : OW'(rsh);
                bus.Sat  <= sat_hi || sat_lo;
            end
        end
    end

    // Writes during accumulation would corrupt the sample in flight, so they are refused.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NP; i++) h[i] <= '0;
        end else if (bus.CoefWe && !busy) begin
            h[bus.CoefAddr] <= bus.CoefData;
        end
    end
endmodule
